// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract unit.
package alu_pkg;

    // Operation encodings on the op input
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_RSB = 2'b10;
    localparam logic [1:0] OP_ADC = 2'b11;

    // Control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the {N,Z,C,V} flags vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit adder slice; also exposes the carry into its top bit.
module addsub_digit #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] w_full;

    // Ripple sum of the slice with carry-in
    always_comb begin
        w_full   = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        sum      = w_full[DIGIT-1:0];
        cout     = w_full[DIGIT];
        // Sum bit = x ^ y ^ carry_in, so the top-bit carry-in falls out without a second adder
        c_msb_in = w_full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: WIDTH-bit result produced DIGIT bits per cycle, NZCV flags.
module serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned NCHUNK = WIDTH / DIGIT;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_addsub: WIDTH (%0d) must be a non-zero multiple of DIGIT (%0d)",
               WIDTH, DIGIT);
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic [WIDTH-1:0] w_cap_x;
    logic [WIDTH-1:0] w_cap_y;
    logic             w_cap_c;
    logic [31:0]      w_base;
    logic [DIGIT-1:0] w_x_chunk;
    logic [DIGIT-1:0] w_y_chunk;
    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb_in;
    logic [WIDTH-1:0] w_res_full;
    logic [3:0]       w_flags;

    // Operand preparation: subtraction is x + ~y + 1
    always_comb begin
        w_cap_x = a;
        w_cap_y = b;
        w_cap_c = 1'b0;
        case (op)
            OP_ADD: ;
            OP_SUB: begin
                w_cap_y = ~b;
                w_cap_c = 1'b1;
            end
            OP_RSB: begin
                w_cap_x = b;
                w_cap_y = ~a;
                w_cap_c = 1'b1;
            end
            OP_ADC: w_cap_c = cin;
            default: ;
        endcase
    end

    // Select the chunk addressed by the counter and merge its sum into the result
    always_comb begin
        w_base     = 32'(r_cnt) * DIGIT;
        w_x_chunk  = r_x[w_base +: DIGIT];
        w_y_chunk  = r_y[w_base +: DIGIT];
        w_res_full = r_result;
        w_res_full[w_base +: DIGIT] = w_sum;
    end

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x        (w_x_chunk),
        .y        (w_y_chunk),
        .cin      (r_carry),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_c_msb_in)
    );

    // Flags from the completed result; only meaningful on the last chunk
    always_comb begin
        w_flags         = 4'b0000;
        w_flags[FLAG_N] = w_res_full[WIDTH-1];
        w_flags[FLAG_Z] = (w_res_full == '0);
        w_flags[FLAG_C] = w_cout;
        w_flags[FLAG_V] = w_c_msb_in ^ w_cout;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = BUSY;
            end
            BUSY: begin
                if (r_cnt == LAST) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Datapath: capture operands, then accumulate one chunk per BUSY cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= w_cap_x;
                        r_y     <= w_cap_y;
                        r_carry <= w_cap_c;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_result <= w_res_full;
                    r_carry  <= w_cout;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_flags <= w_flags;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule
